rt_gray_rx: RTL and testbench
=============================

Name: rt_gray_rx

Overview:
- Destination-side receiver for a gray-coded count, e.g. from rt_bin_cnt plus rt_bin2gray, generated in another clock domain.
- Synchronises the gray bus into rt_i_clk, converts it back to binary and registers it.
- Classifies every observed change as increment, decrement or illegal jump, so a downstream consumer gets a clean binary count plus step events.
- Sits directly downstream of the gray encoder, on the far side of the clock crossing.

Parameters:
- W, 32: gray/binary width in bits, valid range 2..32.
- SYNC_STG, 2: number of synchroniser flops, minimum 2.

Ports:
- rt_i_clk  in  1  destination clock.
- rt_i_rst  in  1  asynchronous reset, active high.
- rt_i_gray  in  W  gray count from the source domain, asynchronous to rt_i_clk.
- rt_i_err_clr  in  1  synchronous clear of rt_o_err_stky.
- rt_o_gray_sync  out  W  synchronised gray value (last synchroniser flop).
- rt_o_bin  out  W  registered binary equivalent of the synchronised gray.
- rt_o_vld  out  1  one-cycle pulse: legal ±1 step observed.
- rt_o_dir  out  1  direction of last legal step: 0 = increase, 1 = decrease (same sense as rt_i_inc_n of the counter).
- rt_o_err  out  1  one-cycle pulse: illegal jump observed.
- rt_o_err_stky  out  1  sticky error flag.
- rt_o_eqnz  out  1  1 when rt_o_bin != 0.

Behaviour:
- Reset: rt_i_rst high asynchronously clears every flop. This covers the synchroniser chain, the previous-sample register and all outputs; all outputs read 0 while reset is held.
- Operation resumes on the first rising edge after rt_i_rst deasserts.
- Synchroniser: SYNC_STG flops in series, no logic between them. g_s = last stage = rt_o_gray_sync.
- Conversion (combinational): b_new[W-1] = g_s[W-1]; b_new[i] = b_new[i+1] ^ g_s[i].
- Registered state: b_prev = rt_o_bin, i.e. the binary value of the previous g_s.
- Each clock edge, compute diff = (b_new - b_prev) mod 2^W, then:
  - diff == 0: rt_o_vld = 0, rt_o_err = 0; rt_o_dir holds.
  - diff == 1: rt_o_vld = 1, rt_o_dir = 0.
  - diff == 2^W-1: rt_o_vld = 1, rt_o_dir = 1.
  - any other diff: rt_o_err = 1, rt_o_vld = 0, rt_o_dir holds, rt_o_err_stky set.
- rt_o_bin <= b_new every cycle regardless of classification, so the block resyncs after an error.
- rt_o_eqnz <= (b_new != 0), registered alongside rt_o_bin.
- Latency: a stable rt_i_gray change meeting setup before edge e0 appears in the outputs as follows:
  - rt_o_gray_sync updates after edge e0+(SYNC_STG-1).
  - rt_o_bin, rt_o_vld, rt_o_err and rt_o_eqnz update after edge e0+SYNC_STG. That is SYNC_STG+1 edges inclusive, 3 for the default.
- Wrap-around is legal: all-ones to 0 is an increment, 0 to all-ones is a decrement.
- A gray input that changes by one bit but maps to a binary jump other than ±1 is an error; the binary difference is authoritative, not the bit count.
- Sticky error:
  - Set on any rt_o_err.
  - Cleared by rt_i_err_clr on the next edge.
  - If rt_i_err_clr and a new error occur on the same edge, set wins and rt_o_err_stky stays 1.
- No handshake or backpressure: events are pulses and must be consumed in the cycle they appear.
- The first sample after reset is compared against b_prev = 0. A nonzero gray present at reset release is classified like any other change (±1 or error).
- Per-bit metastability is resolved by the synchroniser. Multi-bit skew is not, and is caught by the error classification.

Test Plan (W=4, SYNC_STG=2):
- Reset: assert rt_i_rst mid-clock with rt_i_gray=1000 -> all outputs 0 immediately, without waiting for a clock edge; they stay 0 until release.
- Increment: gray 0000->0001 before edge e0 -> after e2 rt_o_bin=0001, rt_o_vld=1 for exactly one cycle, rt_o_dir=0, rt_o_eqnz=1; rt_o_gray_sync=0001 after e1.
- Decrement: gray 0001->0000 -> rt_o_bin=0000, rt_o_vld pulse, rt_o_dir=1, rt_o_eqnz=0, rt_o_err=0.
- Wrap: step gray through bin 14 (1001) -> 15 (1000) -> 0 (0000), holding each for 4 cycles -> three vld pulses with dir=0, final rt_o_bin=0000, no error.
- Illegal jump: gray 0000->0011 (bin 2) -> rt_o_err one-cycle pulse, rt_o_vld=0, rt_o_err_stky=1, rt_o_bin=0010.
  - Then pulse rt_i_err_clr -> rt_o_err_stky=0.
  - Then jump to 0110 (bin 4) with rt_i_err_clr asserted on the same edge the error registers -> rt_o_err_stky=1.
- Reset mid-stream: count up to bin 5 (gray 0111), then assert rt_i_rst -> rt_o_bin=0 and rt_o_err_stky=0 immediately.
  - Release with gray 0111 held -> 3 edges later rt_o_bin=0101 and rt_o_err pulse, since 0->5 is an illegal jump.

Source files
------------

// File: rtl/rt_gray_rx.sv
// rt_gray_rx
// Destination-side receiver for a gray-coded count produced in another clock
// domain. The gray bus is passed through a plain flop synchroniser, converted
// back to binary and registered. Every change of the registered binary value
// is classified as a +1 step, a -1 step or an illegal jump.
//
// Parameters:
//   W         gray/binary width in bits (2..32)
//   SYNC_STG  number of synchroniser flops (>= 2)
//
// Ports:
//   rt_i_clk        destination clock
//   rt_i_rst        asynchronous reset, active high
//   rt_i_gray       gray count, asynchronous to rt_i_clk
//   rt_i_err_clr    synchronous clear of the sticky error flag
//   rt_o_gray_sync  synchronised gray value (last synchroniser flop)
//   rt_o_bin        registered binary equivalent of rt_o_gray_sync
//   rt_o_vld        one-cycle pulse, legal +/-1 step observed
//   rt_o_dir        direction of the last legal step (0 = up, 1 = down)
//   rt_o_err        one-cycle pulse, illegal jump observed
//   rt_o_err_stky   sticky error flag
//   rt_o_eqnz       high when rt_o_bin is nonzero

module rt_gray_rx #(
    parameter int W        = 32,
    parameter int SYNC_STG = 2
) (
    input  logic         rt_i_clk,
    input  logic         rt_i_rst,
    input  logic [W-1:0] rt_i_gray,
    input  logic         rt_i_err_clr,
    output logic [W-1:0] rt_o_gray_sync,
    output logic [W-1:0] rt_o_bin,
    output logic         rt_o_vld,
    output logic         rt_o_dir,
    output logic         rt_o_err,
    output logic         rt_o_err_stky,
    output logic         rt_o_eqnz
);

    localparam logic [W-1:0] ONE = W'(1);
    localparam logic [W-1:0] ALL_ONES = '1;

    logic [W-1:0] sync_q [SYNC_STG];
    logic [W-1:0] g_s;
    logic [W-1:0] b_new;
    logic [W-1:0] diff;
    logic         step_up;
    logic         step_dn;
    logic         step_err;

    // Synchroniser chain: plain flops in series, no logic in between, so each
    // bit resolves metastability independently.
    always_ff @(posedge rt_i_clk or posedge rt_i_rst) begin
        if (rt_i_rst) begin
            for (int i = 0; i < SYNC_STG; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= rt_i_gray;
            for (int i = 1; i < SYNC_STG; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign g_s            = sync_q[SYNC_STG-1];
    assign rt_o_gray_sync = g_s;

    // Gray to binary: each binary bit is the XOR of all gray bits at or above
    // it, which is the same as XOR-folding the gray value shifted right by
    // every amount from 0 to W-1.
    always_comb begin
        b_new = g_s;
        for (int i = 1; i < W; i++) begin
            b_new = b_new ^ (g_s >> i);
        end
    end

    // Step classification uses the modular binary difference, so wrap-around
    // counts as a legal step and a one-bit gray change that lands far away in
    // binary is still flagged.
    always_comb begin
        diff     = b_new - rt_o_bin;
        step_up  = (diff == ONE);
        step_dn  = (diff == ALL_ONES);
        step_err = (diff != '0) && !step_up && !step_dn;
    end

    // Registered outputs. The binary value always follows the synchronised
    // input, so the block realigns itself on the cycle after any error. A new
    // error outranks a simultaneous clear of the sticky flag.
    always_ff @(posedge rt_i_clk or posedge rt_i_rst) begin
        if (rt_i_rst) begin
            rt_o_bin      <= '0;
            rt_o_vld      <= 1'b0;
            rt_o_dir      <= 1'b0;
            rt_o_err      <= 1'b0;
            rt_o_err_stky <= 1'b0;
            rt_o_eqnz     <= 1'b0;
        end else begin
            rt_o_bin  <= b_new;
            rt_o_eqnz <= (b_new != '0);
            rt_o_vld  <= step_up || step_dn;
            rt_o_err  <= step_err;
            if (step_up) begin
                rt_o_dir <= 1'b0;
            end else if (step_dn) begin
                rt_o_dir <= 1'b1;
            end
            if (step_err) begin
                rt_o_err_stky <= 1'b1;
            end else if (rt_i_err_clr) begin
                rt_o_err_stky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rt_gray_rx.sv
// tb_rt_gray_rx
// Self-checking bench for rt_gray_rx with W=4, SYNC_STG=2. A behavioural model
// tracks what the outputs must be from the gray input history; a compare
// process checks every cycle, and directed scenarios add literal checks.

module tb_rt_gray_rx;

    localparam int W        = 4;
    localparam int SYNC_STG = 2;

    logic         tb_r_clk = 1'b0;
    logic         rst      = 1'b0;
    logic [W-1:0] gray     = '0;
    logic         err_clr  = 1'b0;

    logic [W-1:0] dut_gray_sync;
    logic [W-1:0] dut_bin;
    logic         dut_vld;
    logic         dut_dir;
    logic         dut_err;
    logic         dut_err_stky;
    logic         dut_eqnz;

    int checks = 0;
    int errors = 0;
    int vld_cnt = 0;
    int dn_cnt  = 0;
    logic chk_en = 1'b0;

    // Model state
    logic [W-1:0] sq [$];
    logic [W-1:0] m_sync = '0;
    logic [W-1:0] m_bin  = '0;
    logic         m_vld  = 1'b0;
    logic         m_dir  = 1'b0;
    logic         m_err  = 1'b0;
    logic         m_stky = 1'b0;
    logic         m_eqnz = 1'b0;

    rt_gray_rx #(.W(W), .SYNC_STG(SYNC_STG)) dut (
        .rt_i_clk       (tb_r_clk),
        .rt_i_rst       (rst),
        .rt_i_gray      (gray),
        .rt_i_err_clr   (err_clr),
        .rt_o_gray_sync (dut_gray_sync),
        .rt_o_bin       (dut_bin),
        .rt_o_vld       (dut_vld),
        .rt_o_dir       (dut_dir),
        .rt_o_err       (dut_err),
        .rt_o_err_stky  (dut_err_stky),
        .rt_o_eqnz      (dut_eqnz)
    );

    always #5 tb_r_clk = ~tb_r_clk;

    function automatic int g2b(input int g);
        int b;
        b = 0;
        for (int i = 0; i < W; i++) begin
            b = b ^ (g >> i);
        end
        return b % (1 << W);
    endfunction

    function automatic int b2g(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] g, input int cycles);
        gray = g;
        repeat (cycles) @(negedge tb_r_clk);
    endtask

    // Model: the synchroniser is a pure delay of SYNC_STG samples, the binary
    // output follows one edge after that, and each change is classified by
    // its modular distance from the previous binary value.
    always @(posedge tb_r_clk or posedge rst) begin
        int bnew;
        int d;
        if (rst) begin
            sq = {};
            repeat (SYNC_STG) sq.push_back('0);
            m_sync = '0;
            m_bin  = '0;
            m_vld  = 1'b0;
            m_dir  = 1'b0;
            m_err  = 1'b0;
            m_stky = 1'b0;
            m_eqnz = 1'b0;
        end else if (sq.size() == SYNC_STG) begin
            bnew  = g2b(int'(sq[0]));
            d     = (bnew - int'(m_bin) + (1 << W)) % (1 << W);
            m_vld = 1'b0;
            m_err = 1'b0;
            if (d == 1) begin
                m_vld = 1'b1;
                m_dir = 1'b0;
            end else if (d == (1 << W) - 1) begin
                m_vld = 1'b1;
                m_dir = 1'b1;
            end else if (d != 0) begin
                m_err = 1'b1;
            end
            if (m_err) m_stky = 1'b1;
            else if (err_clr) m_stky = 1'b0;
            m_bin  = W'(bnew);
            m_eqnz = (bnew != 0);
            sq.push_back(gray);
            void'(sq.pop_front());
            m_sync = sq[0];
        end
    end

    // Per-cycle comparison against the model, sampled after the edge settles.
    always @(posedge tb_r_clk) begin
        #2;
        if (chk_en) begin
            checkOutput("gray_sync", 32'(dut_gray_sync), 32'(m_sync));
            checkOutput("bin",       32'(dut_bin),       32'(m_bin));
            checkOutput("vld",       32'(dut_vld),       32'(m_vld));
            checkOutput("dir",       32'(dut_dir),       32'(m_dir));
            checkOutput("err",       32'(dut_err),       32'(m_err));
            checkOutput("err_stky",  32'(dut_err_stky),  32'(m_stky));
            checkOutput("eqnz",      32'(dut_eqnz),      32'(m_eqnz));
            if (dut_vld === 1'b1) vld_cnt++;
            if (dut_vld === 1'b1 && dut_dir === 1'b1) dn_cnt++;
        end
    end

    initial begin
        int vbase;
        int dbase;

        // Asynchronous reset asserted mid-cycle with a nonzero gray input.
        gray = 4'b1000;
        repeat (2) @(posedge tb_r_clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("rst_gray_sync", 32'(dut_gray_sync), 32'h0);
        checkOutput("rst_bin",       32'(dut_bin),       32'h0);
        checkOutput("rst_vld",       32'(dut_vld),       32'h0);
        checkOutput("rst_dir",       32'(dut_dir),       32'h0);
        checkOutput("rst_err",       32'(dut_err),       32'h0);
        checkOutput("rst_stky",      32'(dut_err_stky),  32'h0);
        checkOutput("rst_eqnz",      32'(dut_eqnz),      32'h0);
        chk_en = 1'b1;
        @(negedge tb_r_clk);
        gray = 4'b0000;
        repeat (2) @(negedge tb_r_clk);
        checkOutput("rst_hold_bin",  32'(dut_bin),       32'h0);
        checkOutput("rst_hold_sync", 32'(dut_gray_sync), 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge tb_r_clk);

        // Increment 0 -> 1
        gray = 4'b0001;
        @(posedge tb_r_clk);
        @(posedge tb_r_clk); #2;
        checkOutput("inc_sync_e1", 32'(dut_gray_sync), 32'h1);
        checkOutput("inc_bin_e1",  32'(dut_bin),       32'h0);
        @(posedge tb_r_clk); #2;
        checkOutput("inc_bin",  32'(dut_bin),  32'h1);
        checkOutput("inc_vld",  32'(dut_vld),  32'h1);
        checkOutput("inc_dir",  32'(dut_dir),  32'h0);
        checkOutput("inc_eqnz", 32'(dut_eqnz), 32'h1);
        @(posedge tb_r_clk); #2;
        checkOutput("inc_vld_off", 32'(dut_vld), 32'h0);
        @(negedge tb_r_clk);

        // Decrement 1 -> 0
        gray = 4'b0000;
        repeat (3) @(posedge tb_r_clk);
        #2;
        checkOutput("dec_bin",  32'(dut_bin),  32'h0);
        checkOutput("dec_vld",  32'(dut_vld),  32'h1);
        checkOutput("dec_dir",  32'(dut_dir),  32'h1);
        checkOutput("dec_eqnz", 32'(dut_eqnz), 32'h0);
        checkOutput("dec_err",  32'(dut_err),  32'h0);
        repeat (3) @(negedge tb_r_clk);

        // Count up to 13, then wrap through 14, 15, 0
        for (int b = 1; b <= 13; b++) begin
            applyStimulus(W'(b2g(b)), 4);
        end
        vbase = vld_cnt;
        dbase = dn_cnt;
        applyStimulus(4'b1001, 4);
        applyStimulus(4'b1000, 4);
        applyStimulus(4'b0000, 4);
        checkOutput("wrap_pulses",    32'(vld_cnt - vbase), 32'd3);
        checkOutput("wrap_dn_pulses", 32'(dn_cnt - dbase),  32'd0);
        checkOutput("wrap_bin",       32'(dut_bin),         32'h0);
        checkOutput("wrap_stky",      32'(dut_err_stky),    32'h0);

        // Illegal jump 0 -> 2
        gray = 4'b0011;
        repeat (3) @(posedge tb_r_clk);
        #2;
        checkOutput("jmp_err",  32'(dut_err),      32'h1);
        checkOutput("jmp_vld",  32'(dut_vld),      32'h0);
        checkOutput("jmp_stky", 32'(dut_err_stky), 32'h1);
        checkOutput("jmp_bin",  32'(dut_bin),      32'h2);
        @(posedge tb_r_clk); #2;
        checkOutput("jmp_err_off",  32'(dut_err),      32'h0);
        checkOutput("jmp_stky_hold", 32'(dut_err_stky), 32'h1);
        @(negedge tb_r_clk);
        err_clr = 1'b1;
        @(negedge tb_r_clk);
        err_clr = 1'b0;
        checkOutput("clr_stky", 32'(dut_err_stky), 32'h0);

        // Jump 2 -> 4 with the clear landing on the same edge as the error
        gray = 4'b0110;
        @(negedge tb_r_clk);
        @(negedge tb_r_clk);
        err_clr = 1'b1;
        @(posedge tb_r_clk); #2;
        checkOutput("setwin_err",  32'(dut_err),      32'h1);
        checkOutput("setwin_stky", 32'(dut_err_stky), 32'h1);
        checkOutput("setwin_bin",  32'(dut_bin),      32'h4);
        @(negedge tb_r_clk);
        err_clr = 1'b0;
        repeat (2) @(negedge tb_r_clk);

        // Step to 5, then reset mid-stream with gray held
        applyStimulus(4'b0111, 4);
        checkOutput("pre_rst_bin", 32'(dut_bin), 32'h5);
        @(posedge tb_r_clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("mid_rst_bin",  32'(dut_bin),      32'h0);
        checkOutput("mid_rst_stky", 32'(dut_err_stky), 32'h0);
        checkOutput("mid_rst_err",  32'(dut_err),      32'h0);
        @(negedge tb_r_clk);
        @(negedge tb_r_clk);
        rst = 1'b0;
        repeat (3) @(posedge tb_r_clk);
        #2;
        checkOutput("rel_bin",  32'(dut_bin),      32'h5);
        checkOutput("rel_err",  32'(dut_err),      32'h1);
        checkOutput("rel_vld",  32'(dut_vld),      32'h0);
        checkOutput("rel_stky", 32'(dut_err_stky), 32'h1);
        repeat (3) @(negedge tb_r_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
